// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter.
// Grants the shared bus to one master at a time and holds the grant until that
// master reports done or withdraws its request. A one-cycle RELEASE state sits
// between owners. An owner that holds the bus for TIMEOUT_CYCLES cycles without
// done is aborted.
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   m1_req/m2_req  bus requests from master 1 / master 2
//   m1_done/m2_done transaction complete, honoured only from the granted master
//   m1_grant/m2_grant registered one-hot (or zero) grants
//   m_sel          bus mux select, 0 = master 1, 1 = master 2
//   bus_busy       high whenever either grant is high
//   timeout_abort  one-cycle pulse during RELEASE; bit0 = m1, bit1 = m2
module bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m1_req,
  input  logic       m2_req,
  input  logic       m1_done,
  input  logic       m2_done,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic       m_sel,
  output logic       bus_busy,
  output logic [1:0] timeout_abort
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_M1 = 2'd1,
    GRANT_M2 = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             last_m2, last_m2_next;   // 1 = master 2 owned the bus last
  logic             m_sel_next;
  logic [1:0]       abort_next;

  // State, counter and registered outputs; outputs are decoded from next state
  // so they line up with the state they describe without any input-to-output path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      last_m2       <= 1'b1;
      m1_grant      <= 1'b0;
      m2_grant      <= 1'b0;
      bus_busy      <= 1'b0;
      m_sel         <= 1'b0;
      timeout_abort <= 2'b00;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      last_m2       <= last_m2_next;
      m1_grant      <= (state_next == GRANT_M1);
      m2_grant      <= (state_next == GRANT_M2);
      bus_busy      <= (state_next == GRANT_M1) || (state_next == GRANT_M2);
      m_sel         <= m_sel_next;
      timeout_abort <= abort_next;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    last_m2_next = last_m2;
    m_sel_next   = m_sel;
    abort_next   = 2'b00;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (m1_req && (!m2_req || last_m2)) begin
          state_next = GRANT_M1;
          m_sel_next = 1'b0;
        end else if (m2_req) begin
          state_next = GRANT_M2;
          m_sel_next = 1'b1;
        end
      end
      GRANT_M1: begin
        // Done (or withdrawal) takes priority over a coincident timeout.
        if (m1_done || !m1_req) begin
          state_next   = RELEASE;
          last_m2_next = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_next   = RELEASE;
          last_m2_next = 1'b0;
          abort_next   = 2'b01;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      GRANT_M2: begin
        if (m2_done || !m2_req) begin
          state_next   = RELEASE;
          last_m2_next = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_next   = RELEASE;
          last_m2_next = 1'b1;
          abort_next   = 2'b10;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RELEASE: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (TIMEOUT_CYCLES = 8).
// Outputs are sampled on the falling edge as {m1_grant, m2_grant, m_sel,
// bus_busy, timeout_abort[1:0]}.
module tb_bus_arbiter;

  logic       clk;
  logic       reset;
  logic       m1_req, m2_req, m1_done, m2_done;
  logic       m1_grant, m2_grant, m_sel, bus_busy;
  logic [1:0] timeout_abort;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] O_IDLE_S0 = 6'b000000;
  localparam logic [5:0] O_IDLE_S1 = 6'b001000;
  localparam logic [5:0] O_G1      = 6'b100100;
  localparam logic [5:0] O_G2      = 6'b011100;
  localparam logic [5:0] O_AB2     = 6'b001010;

  bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .reset(reset),
    .m1_req(m1_req),
    .m2_req(m2_req),
    .m1_done(m1_done),
    .m2_done(m2_done),
    .m1_grant(m1_grant),
    .m2_grant(m2_grant),
    .m_sel(m_sel),
    .bus_busy(bus_busy),
    .timeout_abort(timeout_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] outs();
    return {m1_grant, m2_grant, m_sel, bus_busy, timeout_abort};
  endfunction

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and land on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    check("reset_state", outs(), O_IDLE_S0);
    reset = 1'b0;
  endtask

  logic owner_m2;

  initial begin
    reset = 1'b1;
    m1_req = 1'b0; m2_req = 1'b0; m1_done = 1'b0; m2_done = 1'b0;
    @(negedge clk);
    do_reset();

    // Single requester: grant cycles 1..5, done in cycle 5.
    m1_req = 1'b1;
    step();
    for (int c = 1; c <= 5; c++) begin
      check("single_grant", outs(), O_G1);
      if (c == 5) begin m1_done = 1'b1; m1_req = 1'b0; end
      step();
    end
    m1_done = 1'b0;
    check("single_release", outs(), O_IDLE_S0);
    step();
    check("single_idle", outs(), O_IDLE_S0);

    // Contention after reset: master 1 first, master 2 two cycles after release.
    do_reset();
    m1_req = 1'b1; m2_req = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      check("cont_m1_grant", outs(), O_G1);
    end
    m1_done = 1'b1; m1_req = 1'b0;
    step();
    m1_done = 1'b0;
    check("cont_release", outs(), O_IDLE_S0);
    step();
    check("cont_gap_idle", outs(), O_IDLE_S0);
    for (int c = 1; c <= 3; c++) begin
      step();
      check("cont_m2_grant", outs(), O_G2);
    end
    m2_done = 1'b1; m2_req = 1'b0;
    step();
    m2_done = 1'b0;
    check("cont_m2_release", outs(), O_IDLE_S1);
    step();
    check("cont_m2_idle", outs(), O_IDLE_S1);

    // Round-robin: both held high, two-cycle grants; expect M1, M2, M1, M2.
    m1_req = 1'b1; m2_req = 1'b1;
    owner_m2 = 1'b0;
    for (int g = 0; g < 4; g++) begin
      step();
      check("rr_grant_a", outs(), owner_m2 ? O_G2 : O_G1);
      step();
      check("rr_grant_b", outs(), owner_m2 ? O_G2 : O_G1);
      if (owner_m2) m2_done = 1'b1; else m1_done = 1'b1;
      step();
      m1_done = 1'b0; m2_done = 1'b0;
      check("rr_release", outs(), owner_m2 ? O_IDLE_S1 : O_IDLE_S0);
      step();
      check("rr_idle", outs(), owner_m2 ? O_IDLE_S1 : O_IDLE_S0);
      owner_m2 = ~owner_m2;
    end
    m1_req = 1'b0; m2_req = 1'b0;
    step();

    // Timeout: m2 held 8 cycles, abort pulse in RELEASE, pending m1 then wins.
    m2_req = 1'b1;
    step();
    for (int c = 1; c <= 8; c++) begin
      check("to_m2_grant", outs(), O_G2);
      if (c == 2) m1_req = 1'b1;
      step();
    end
    check("to_abort_pulse", outs(), O_AB2);
    step();
    check("to_abort_cleared", outs(), O_IDLE_S1);
    step();
    check("to_m1_after_abort", outs(), O_G1);
    m1_done = 1'b1; m1_req = 1'b0; m2_req = 1'b0;
    step();
    m1_done = 1'b0;
    check("to_m1_release", outs(), O_IDLE_S0);
    step();

    // Done on the final grant cycle beats the timeout.
    m2_req = 1'b1;
    step();
    for (int c = 1; c <= 8; c++) begin
      check("td_m2_grant", outs(), O_G2);
      if (c == 8) m2_done = 1'b1;
      step();
    end
    check("td_no_abort", outs(), O_IDLE_S1);
    m2_done = 1'b0; m2_req = 1'b0;
    step();
    check("td_idle", outs(), O_IDLE_S1);

    // Withdrawal and stray done.
    m1_req = 1'b1;
    step();
    check("wd_grant", outs(), O_G1);
    m2_done = 1'b1;
    step();
    check("wd_stray_done", outs(), O_G1);
    m2_done = 1'b0;
    m1_req = 1'b0;
    step();
    check("wd_release", outs(), O_IDLE_S0);
    m2_done = 1'b1;
    step();
    check("wd_idle_stray", outs(), O_IDLE_S0);
    m2_done = 1'b0;

    // Reset mid-grant drops grant immediately; master 1 favoured afterwards.
    m2_req = 1'b1;
    step();
    check("rst_pre_grant", outs(), O_G2);
    #2 reset = 1'b1;
    #1 check("rst_async_drop", outs(), O_IDLE_S0);
    m1_req = 1'b1; m2_req = 1'b1;
    @(negedge clk);
    check("rst_held", outs(), O_IDLE_S0);
    reset = 1'b0;
    step();
    check("rst_m1_first", outs(), O_G1);
    m1_req = 1'b0; m2_req = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master round-robin arbiter for the shared system bus.
- Sits between the master ports (e.g. the increment application's master port and a second master) and the bus mux/bridge.
- Grants bus ownership to one requester at a time and holds the grant until that transaction completes.
- Enforces a one-cycle turnaround between owners, and aborts any owner that holds the bus past a timeout.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles a grant may be held without done; legal range 2..65535; counter is 16 bits.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous active-high reset
m1_req  input  1  master 1 requests bus (high while its instruction is non-idle)
m2_req  input  1  master 2 requests bus
m1_done  input  1  master 1 transaction complete (its tx_done), sampled only while master 1 is granted
m2_done  input  1  master 2 transaction complete, sampled only while master 2 is granted
m1_grant  output  1  master 1 owns the bus
m2_grant  output  1  master 2 owns the bus
m_sel  output  1  bus mux select: 0 = master 1, 1 = master 2
bus_busy  output  1  high whenever either grant is high
timeout_abort  output  2  one-cycle pulse; bit0 = master 1 aborted, bit1 = master 2 aborted

Behaviour:
- Reset (asynchronous, clk not required) forces:
  - state IDLE;
  - m1_grant = 0, m2_grant = 0, bus_busy = 0;
  - m_sel = 0, timeout_abort = 0;
  - timeout counter = 0;
  - last_owner = M2, so master 1 wins the first contention.
- All outputs are registered. No combinational path from any input to any output.
- States are IDLE, GRANT_M1, GRANT_M2, RELEASE.
- IDLE:
  - Only m1_req high → GRANT_M1 on the next edge.
  - Only m2_req high → GRANT_M2 on the next edge.
  - Both high → grant the master that is not last_owner.
  - Neither high → stay in IDLE; m_sel holds its previous value.
  - Latency from req sampled high in IDLE to grant high is 1 cycle.
- GRANT_Mx (x = 1 or 2):
  - mx_grant = 1, bus_busy = 1, m_sel = x-1; counter increments every cycle from 0.
  - Exit on mx_done = 1: grant drops on the next edge, last_owner = x, go to RELEASE, no abort.
  - Exit on mx_req = 0 (master withdrew without done): treated as done; no abort.
  - Exit on counter == TIMEOUT_CYCLES-1 with mx_done = 0: timeout_abort[x-1] = 1 for exactly the cycle in which the state is RELEASE, last_owner = x, go to RELEASE.
  - The other master's req is ignored while in GRANT_Mx. No preemption.
- RELEASE:
  - Exactly one cycle; both grants 0, bus_busy 0; counter cleared; then IDLE.
  - Requests sampled during RELEASE are not granted until evaluated in IDLE.
  - Minimum gap between consecutive grants is therefore 2 cycles: RELEASE, then IDLE evaluation.
- Simultaneous done and timeout on the same cycle: done wins; no abort pulse.
- A done input from a non-granted master is ignored in every state.
- Grants are one-hot or all zero at all times. m1_grant and m2_grant are never both high.
- A master that keeps req high after release is granted again only if the other master is not requesting when IDLE evaluates.
- Reset asserted mid-grant drops the grant immediately (asynchronously). No abort pulse is generated. After reset release, arbitration restarts with master 1 favoured.

Test Plan:
- Single requester: m1_req high at cycle 0, m1_done pulse at cycle 5 → m1_grant high cycles 1..5, low from 6; bus_busy mirrors it; m_sel = 0 throughout; timeout_abort stays 0.
- Contention after reset: m1_req and m2_req both high from cycle 0, each done 3 cycles after its grant → m1 granted first; m2_grant rises exactly 2 cycles after m1_grant falls; m_sel = 1 during the m2 grant; the grants never overlap.
- Round-robin fairness: both requests held high continuously with done 2 cycles after each grant → grant order M1, M2, M1, M2 over 4 grants.
- Timeout: TIMEOUT_CYCLES = 8, m2_req high, m2_done never asserted → m2_grant high for exactly 8 cycles; timeout_abort = 2'b10 for 1 cycle; a pending m1_req is then granted. Repeat with m2_done asserted on the 8th grant cycle → no abort.
- Withdrawal and stray done: master 1 granted, m1_req drops without done → release with no abort. m2_done pulsed while master 1 is granted → no effect.
- Reset mid-grant: assert reset between clock edges during GRANT_M2 → m2_grant, bus_busy and m_sel go to 0 immediately. After release with both requests high, master 1 is granted first.
